// File: rtl/vga_sync_monitor_if.sv
// VGA monitor bus: the sampled stream and probe setup flow into the monitor,
// recovered position, lock status, error pulses and the probe capture flow out.
interface vga_sync_monitor_if;
  logic       Hsinc;
  logic       Vsinc;
  logic [2:0] Rojo;
  logic [2:0] Verde;
  logic [1:0] Azul;
  logic [9:0] probe_x;
  logic [9:0] probe_y;
  logic [9:0] posX;
  logic [9:0] posY;
  logic       active;
  logic       locked;
  logic       line_err;
  logic       frame_err;
  logic [7:0] probe_color;
  logic       probe_valid;
  logic [7:0] frame_count;

  // Source side: drives the VGA pins and the probe coordinate.
  modport master (
    output Hsinc, Vsinc, Rojo, Verde, Azul, probe_x, probe_y,
    input  posX, posY, active, locked, line_err, frame_err,
           probe_color, probe_valid, frame_count
  );

  // Monitor side.
  modport slave (
    input  Hsinc, Vsinc, Rojo, Verde, Azul, probe_x, probe_y,
    output posX, posY, active, locked, line_err, frame_err,
           probe_color, probe_valid, frame_count
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing monitor: registers the pins, recovers hcnt/vcnt
// from sync falling edges, checks line/frame lengths, tracks lock and
// captures the colour at a probe coordinate.
module vga_sync_monitor #(
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             Clk,
  input  logic             reset,
  vga_sync_monitor_if.slave vga
);

  localparam logic [9:0] CNT_MAX = 10'd1023;
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_e;

  logic       hs_q, hs_d, hs_q2, hs_d2, vs_q, vs_d, vs_line_q, vs_line_d;
  logic [7:0] rgb_q, rgb_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       h_seen_q, h_seen_d, v_seen_q, v_seen_d;
  logic       frame_bad_q, frame_bad_d;
  logic       line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic       timeout_q, timeout_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic [7:0] good_q, good_d;
  state_e     state_q, state_d;
  logic [7:0] probe_color_q, probe_color_d;
  logic       probe_valid_q, probe_valid_d;

  logic       h_edge, frame_start, timeout, line_bad, frame_len_bad, frame_good;
  logic       win_active;
  logic [9:0] pos_x, pos_y;

  // A sync falling edge is seen one stage behind the pins; the counter
  // timing out (reaching 1023 without an edge) ends the current line.
  assign h_edge        = hs_q2 & ~hs_q;
  assign frame_start   = h_edge & ~vs_q & vs_line_q;
  assign timeout       = ~h_edge & (hcnt_q == CNT_MAX - 10'd1);
  assign line_bad      = h_edge & h_seen_q & (hcnt_q != H_LAST);
  assign frame_len_bad = frame_start & v_seen_q & (vcnt_q != V_LAST);
  // A line error on the frame-start edge belongs to the frame that is ending.
  assign frame_good    = frame_start & v_seen_q & ~frame_bad_q & ~line_bad & ~frame_len_bad;

  assign win_active = (hcnt_q >= H_START) && (hcnt_q < H_END) &&
                      (vcnt_q >= V_START) && (vcnt_q < V_END);
  assign pos_x      = win_active ? hcnt_q - H_START : 10'd0;
  assign pos_y      = win_active ? vcnt_q - V_START : 10'd0;

  // Input sampling, position counters and the line/frame length checks.
  always_comb begin
    hs_d          = vga.Hsinc;
    hs_d2         = hs_q;
    vs_d          = vga.Vsinc;
    rgb_d         = {vga.Rojo, vga.Verde, vga.Azul};
    vs_line_d     = vs_line_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    h_seen_d      = h_seen_q;
    v_seen_d      = v_seen_q;
    frame_bad_d   = frame_bad_q;
    frame_count_d = frame_count_q;
    line_err_d    = line_bad | timeout;
    frame_err_d   = frame_len_bad;
    timeout_d     = timeout;

    if (h_edge) begin
      hcnt_d    = 10'd0;
      vs_line_d = vs_q;
    end else if (hcnt_q != CNT_MAX) begin
      hcnt_d = hcnt_q + 10'd1;
    end

    if (frame_start) begin
      vcnt_d = 10'd0;
    end else if (h_edge && (vcnt_q != CNT_MAX)) begin
      vcnt_d = vcnt_q + 10'd1;
    end

    if (timeout) begin
      h_seen_d = 1'b0;
      v_seen_d = 1'b0;
    end else begin
      if (h_edge)      h_seen_d = 1'b1;
      if (frame_start) v_seen_d = 1'b1;
    end

    if (frame_start)     frame_bad_d = 1'b0;
    else if (line_err_d) frame_bad_d = 1'b1;

    if (frame_good) frame_count_d = frame_count_q + 8'd1;
  end

  // Lock state machine: acquires on frame starts, drops on registered errors.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    case (state_q)
      UNLOCKED: begin
        if (frame_start) begin
          state_d = ACQUIRE;
          good_d  = 8'd0;
        end
      end
      ACQUIRE: begin
        if (frame_start && v_seen_q) begin
          if (frame_good) begin
            good_d = good_q + 8'd1;
            if (good_q + 8'd1 >= LOCK_N) state_d = LOCKED;
          end else begin
            good_d = 8'd0;
          end
        end
      end
      LOCKED: begin
        if (line_err_q || frame_err_q) state_d = UNLOCKED;
      end
      default: state_d = UNLOCKED;
    endcase
    if (timeout_q) state_d = UNLOCKED;
  end

  // Probe capture of the registered pixel at the requested visible coordinate.
  always_comb begin
    probe_valid_d = (state_q == LOCKED) && win_active &&
                    (pos_x == vga.probe_x) && (pos_y == vga.probe_y);
    probe_color_d = probe_valid_d ? rgb_q : probe_color_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      hs_q          <= 1'b1;
      hs_q2         <= 1'b1;
      vs_q          <= 1'b1;
      vs_line_q     <= 1'b1;
      rgb_q         <= 8'd0;
      hcnt_q        <= 10'd0;
      vcnt_q        <= 10'd0;
      h_seen_q      <= 1'b0;
      v_seen_q      <= 1'b0;
      frame_bad_q   <= 1'b0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      timeout_q     <= 1'b0;
      frame_count_q <= 8'd0;
      good_q        <= 8'd0;
      state_q       <= UNLOCKED;
      probe_color_q <= 8'd0;
      probe_valid_q <= 1'b0;
    end else begin
      hs_q          <= hs_d;
      hs_q2         <= hs_d2;
      vs_q          <= vs_d;
      vs_line_q     <= vs_line_d;
      rgb_q         <= rgb_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      h_seen_q      <= h_seen_d;
      v_seen_q      <= v_seen_d;
      frame_bad_q   <= frame_bad_d;
      line_err_q    <= line_err_d;
      frame_err_q   <= frame_err_d;
      timeout_q     <= timeout_d;
      frame_count_q <= frame_count_d;
      good_q        <= good_d;
      state_q       <= state_d;
      probe_color_q <= probe_color_d;
      probe_valid_q <= probe_valid_d;
    end
  end

  assign vga.posX        = pos_x;
  assign vga.posY        = pos_y;
  assign vga.active      = win_active;
  assign vga.locked      = (state_q == LOCKED);
  assign vga.line_err    = line_err_q;
  assign vga.frame_err   = frame_err_q;
  assign vga.probe_color = probe_color_q;
  assign vga.probe_valid = probe_valid_q;
  assign vga.frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Bench for vga_sync_monitor using a reduced 20x12 timing so whole frames
// are short; stream generator records what it drove and derives expectations.
module tb_vga_sync_monitor;
  localparam int HS = 4, HBP = 3, HA = 10, HT = 20;
  localparam int VS = 2, VBP = 2, VA = 5, VT = 12;
  localparam int LF = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vga_sync_monitor_if vif();

  vga_sync_monitor #(
    .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .Clk(clk),
    .reset(rst_n),
    .vga(vif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_le = 0, n_fe = 0, n_pv = 0;
  int le_cyc = -1, pv_cyc = -1, exp_pv_cyc = -1, last_fall_cyc = 0;
  logic le_prev = 1'b0, fe_prev = 1'b0;
  logic le_lock_at = 1'b0, le_lock_after = 1'b1, le_active = 1'b1;
  logic fe_lock_at = 1'b0, fe_lock_after = 1'b1;
  logic [7:0] pv_color = 8'd0, exp_color = 8'd0;
  logic f_lk0 = 1'b0, f_lk1 = 1'b0;
  logic [7:0] f_fc1 = 8'd0;
  logic force_en = 1'b0;
  logic [7:0] force_val = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one pin cycle, wait for the edge, then log the event outputs.
  task automatic tick(input logic hs, input logic vs, input logic [7:0] rgb);
    vif.Hsinc = hs;
    vif.Vsinc = vs;
    vif.Rojo  = rgb[7:5];
    vif.Verde = rgb[4:2];
    vif.Azul  = rgb[1:0];
    @(posedge clk);
    cyc++;
    #1;
    if (le_prev) le_lock_after = vif.locked;
    if (fe_prev) fe_lock_after = vif.locked;
    le_prev = vif.line_err;
    fe_prev = vif.frame_err;
    if (vif.line_err) begin
      n_le++; le_cyc = cyc; le_lock_at = vif.locked; le_active = vif.active;
    end
    if (vif.frame_err) begin
      n_fe++; fe_lock_at = vif.locked;
    end
    if (vif.probe_valid) begin
      n_pv++; pv_color = vif.probe_color; pv_cyc = cyc;
    end
  endtask

  // One line: pin column k maps to hcnt k-1 and vcnt l once registered.
  task automatic drive_line(input int len, input int l, input bit chkpos);
    for (int k = 0; k < len; k++) begin
      int kx;
      bit vis;
      logic [7:0] rgb;
      kx  = k - 1;
      vis = (kx >= HS + HBP) && (kx < HS + HBP + HA) && (l >= VS + VBP) && (l < VS + VBP + VA);
      rgb = 8'($urandom);
      if (vis && (kx - (HS + HBP)) == int'(vif.probe_x) && (l - (VS + VBP)) == int'(vif.probe_y)) begin
        if (force_en) rgb = force_val;
        exp_color  = rgb;
        exp_pv_cyc = cyc + 2;
      end
      tick((k < HS) ? 1'b0 : 1'b1, (l < VS) ? 1'b0 : 1'b1, rgb);
      if (k == 0) last_fall_cyc = cyc;
      if (l == 0 && k == 0) f_lk0 = vif.locked;
      if (l == 0 && k == 1) begin
        f_lk1 = vif.locked;
        f_fc1 = vif.frame_count;
      end
      if (chkpos && k >= 1) begin
        chk("active", 32'(vif.active), 32'(vis));
        chk("posX", 32'(vif.posX), vis ? 32'(kx - (HS + HBP)) : 32'd0);
        chk("posY", 32'(vif.posY), vis ? 32'(l - (VS + VBP)) : 32'd0);
      end
    end
  endtask

  task automatic drive_frame(input int nlines, input int short_l);
    for (int l = 0; l < nlines; l++)
      drive_line((l == short_l) ? HT - 1 : HT, l, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, 32'(vif.locked), 32'd0);
    chk({tag, "_active"}, 32'(vif.active), 32'd0);
    chk({tag, "_posX"}, 32'(vif.posX), 32'd0);
    chk({tag, "_posY"}, 32'(vif.posY), 32'd0);
    chk({tag, "_line_err"}, 32'(vif.line_err), 32'd0);
    chk({tag, "_frame_err"}, 32'(vif.frame_err), 32'd0);
    chk({tag, "_probe_color"}, 32'(vif.probe_color), 32'd0);
    chk({tag, "_probe_valid"}, 32'(vif.probe_valid), 32'd0);
    chk({tag, "_frame_count"}, 32'(vif.frame_count), 32'd0);
  endtask

  initial begin
    int e;
    vif.probe_x = 10'd0;
    vif.probe_y = 10'd0;

    // Reset held with random pins: all outputs zero.
    for (int i = 0; i < 5; i++) tick(1'($urandom), 1'($urandom), 8'($urandom));
    chk_all_zero("rst_hold");

    // Release with Hsinc low: the spurious edge raises no error.
    n_le = 0; n_fe = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick(1'b0, 1'($urandom), 8'($urandom));
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 8'($urandom));
    chk("release_line_err", 32'(n_le), 32'd0);
    chk("release_frame_err", 32'(n_fe), 32'd0);

    // Clean restart, then three ideal frames.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 8'd0);
    n_le = 0; n_fe = 0;
    drive_frame(VT, -1);
    chk("f1_count", 32'(f_fc1), 32'd0);
    drive_frame(VT, -1);
    chk("f2_locked", 32'(f_lk1), 32'd0);
    chk("f2_count", 32'(f_fc1), 32'd1);
    drive_frame(VT, -1);
    chk("f3_locked_at_start", 32'(f_lk0), 32'd0);
    chk("f3_locked_next", 32'(f_lk1), 32'd1);
    chk("f3_count", 32'(f_fc1), 32'd2);
    chk("ideal_line_err", 32'(n_le), 32'd0);
    chk("ideal_frame_err", 32'(n_fe), 32'd0);

    // Probe at the first visible pixel.
    vif.probe_x = 10'd0; vif.probe_y = 10'd0;
    force_en = 1'b1; force_val = 8'hE3;
    n_pv = 0; exp_pv_cyc = -1;
    drive_frame(VT, -1);
    chk("probe00_pulses", 32'(n_pv), 32'd1);
    chk("probe00_color", 32'(pv_color), 32'hE3);
    chk("probe00_cycle", 32'(pv_cyc), 32'(exp_pv_cyc));

    // Probe at the last visible pixel.
    vif.probe_x = 10'(HA - 1); vif.probe_y = 10'(VA - 1);
    force_val = 8'h1C;
    n_pv = 0; exp_pv_cyc = -1;
    drive_frame(VT, -1);
    chk("probe_last_pulses", 32'(n_pv), 32'd1);
    chk("probe_last_color", 32'(pv_color), 32'h1C);
    chk("probe_last_cycle", 32'(pv_cyc), 32'(exp_pv_cyc));

    // Random probe coordinate with random pixels.
    vif.probe_x = 10'($urandom_range(HA - 1, 0));
    vif.probe_y = 10'($urandom_range(VA - 1, 0));
    force_en = 1'b0;
    n_pv = 0; exp_pv_cyc = -1;
    drive_frame(VT, -1);
    chk("probe_rand_pulses", 32'(n_pv), 32'd1);
    chk("probe_rand_color", 32'(pv_color), 32'(exp_color));
    chk("probe_rand_cycle", 32'(pv_cyc), 32'(exp_pv_cyc));
    chk("f6_count", 32'(f_fc1), 32'd5);
    chk("locked_run_line_err", 32'(n_le), 32'd0);
    chk("locked_run_frame_err", 32'(n_fe), 32'd0);

    // One short line while locked.
    n_le = 0;
    drive_frame(VT, 5);
    chk("short_line_err_count", 32'(n_le), 32'd1);
    chk("short_locked_at_err", 32'(le_lock_at), 32'd1);
    chk("short_locked_after", 32'(le_lock_after), 32'd0);
    n_le = 0; n_pv = 0;
    drive_frame(VT, -1);
    chk("f8_count", 32'(f_fc1), 32'd6);
    chk("f8_locked", 32'(f_lk1), 32'd0);
    chk("f8_no_probe", 32'(n_pv), 32'd0);
    drive_frame(VT, -1);
    chk("f9_locked", 32'(f_lk1), 32'd0);
    chk("f9_count", 32'(f_fc1), 32'd7);
    drive_frame(VT, -1);
    chk("f10_relocked", 32'(f_lk1), 32'd1);
    chk("f10_count", 32'(f_fc1), 32'd8);
    chk("relock_line_err", 32'(n_le), 32'd0);

    // Hsinc stuck high while locked: timeout at hcnt 1023.
    n_le = 0;
    e = last_fall_cyc;
    for (int i = 0; i < 1100; i++) tick(1'b1, 1'b1, 8'($urandom));
    chk("timeout_count", 32'(n_le), 32'd1);
    chk("timeout_cycle", 32'(le_cyc), 32'(e + 1024));
    chk("timeout_active", 32'(le_active), 32'd0);
    chk("timeout_locked_at", 32'(le_lock_at), 32'd1);
    chk("timeout_locked_after", 32'(le_lock_after), 32'd0);

    // Reacquire, then a frame one line short.
    n_le = 0; n_fe = 0;
    drive_frame(VT, -1);
    drive_frame(VT, -1);
    drive_frame(VT - 1, -1);
    chk("f13_locked", 32'(f_lk1), 32'd1);
    chk("f13_count", 32'(f_fc1), 32'd10);
    drive_frame(VT, -1);
    chk("short_frame_err_count", 32'(n_fe), 32'd1);
    chk("short_frame_count", 32'(f_fc1), 32'd10);
    chk("short_frame_locked_at", 32'(fe_lock_at), 32'd1);
    chk("short_frame_locked_after", 32'(fe_lock_after), 32'd0);
    chk("short_frame_line_err", 32'(n_le), 32'd0);

    // Asynchronous reset in the middle of a line.
    for (int i = 0; i < 9; i++) tick((i < HS) ? 1'b0 : 1'b1, 1'b0, 8'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
